// File: rtl/multi_fifo_pkg.sv
// ----------------------------------------------------------------------------
// multi_fifo_pkg
// Shared types, default parameter values and helpers for the multi-channel
// single-clock FIFO (multi_channel_sync_fifo / sync_fifo_channel).
// Optional feature macro: MULTI_FIFO_FWFT_EN (used by sync_fifo_channel).
// ----------------------------------------------------------------------------
package multi_fifo_pkg;

    localparam int DEF_DATA_SIZE           = 8;
    localparam int DEF_ADDR_SIZE           = 3;
    localparam int DEF_NUM_CHANNELS        = 4;
    localparam int DEF_ALMOST_FULL_THRESH  = 6;
    localparam int DEF_ALMOST_EMPTY_THRESH = 1;

    // Per-channel status bundle
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    // Level must represent 0..Depth inclusive, hence one extra bit
    function automatic int level_width(input int addr_size);
        return addr_size + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_channel.sv
// ----------------------------------------------------------------------------
// sync_fifo_channel
// One single-clock FIFO channel with fill level, programmable almost flags
// and overflow/underflow pulses.
//
// Macro MULTI_FIFO_FWFT_EN:
//   defined   - first-word fall-through: DataOut shows the head word
//               combinationally while non-empty, Pop acknowledges it.
//   undefined - registered read, DataOut/DataValid one cycle after a pop.
//
// Ports:
//   Clk, Reset      clock, synchronous active-high reset
//   Push, Pop       write / read requests
//   DataIn          write data
//   DataOut         read data
//   DataValid       DataOut valid
//   Level           occupancy 0..Depth
//   Flags           full/empty/almost_full/almost_empty/overflow/underflow
// ----------------------------------------------------------------------------
module sync_fifo_channel
    import multi_fifo_pkg::*;
#(
    parameter int DataSize          = DEF_DATA_SIZE,
    parameter int AddrSize          = DEF_ADDR_SIZE,
    parameter int AlmostFullThresh  = DEF_ALMOST_FULL_THRESH,
    parameter int AlmostEmptyThresh = DEF_ALMOST_EMPTY_THRESH
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             Push,
    input  logic                             Pop,
    input  logic [DataSize-1:0]              DataIn,
    output logic [DataSize-1:0]              DataOut,
    output logic                             DataValid,
    output logic [level_width(AddrSize)-1:0] Level,
    output fifo_flags_t                      Flags
);

    localparam int LW    = level_width(AddrSize);
    localparam int Depth = 2 ** AddrSize;
    localparam logic [LW-1:0] AF_TH = LW'(AlmostFullThresh);
    localparam logic [LW-1:0] AE_TH = LW'(AlmostEmptyThresh);

    logic [LW-1:0]       r_wptr;
    logic [LW-1:0]       r_rptr;
    logic [DataSize-1:0] r_mem [Depth];
    logic                r_overflow;
    logic                r_underflow;

    logic w_full;
    logic w_empty;
    logic w_push_acc;
    logic w_pop_acc;

    // Extra pointer MSB distinguishes full from empty when low bits match
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AddrSize] != r_rptr[AddrSize]) &&
                     (r_wptr[AddrSize-1:0] == r_rptr[AddrSize-1:0]);
    assign Level   = r_wptr - r_rptr;

    // A pop on a full FIFO frees the slot the push lands in
    assign w_push_acc = !Reset && Push && (!w_full || Pop);
    assign w_pop_acc  = !Reset && Pop && !w_empty;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_acc) r_wptr <= r_wptr + 1'b1;
            if (w_pop_acc)  r_rptr <= r_rptr + 1'b1;
            r_overflow  <= Push && w_full && !Pop;
            r_underflow <= Pop && w_empty;
        end
    end

    // Storage is not reset; only slots behind the write pointer are ever read
    always_ff @(posedge Clk) begin
        if (w_push_acc) r_mem[r_wptr[AddrSize-1:0]] <= DataIn;
    end

`ifdef MULTI_FIFO_FWFT_EN
    assign DataOut   = w_empty ? '0 : r_mem[r_rptr[AddrSize-1:0]];
    assign DataValid = !w_empty;
`else
    logic [DataSize-1:0] r_dout;
    logic                r_dvalid;

    // Non-blocking read sees the old word even when a full-FIFO push
    // overwrites the same slot on this edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_dout   <= '0;
            r_dvalid <= 1'b0;
        end else if (w_pop_acc) begin
            r_dout   <= r_mem[r_rptr[AddrSize-1:0]];
            r_dvalid <= 1'b1;
        end else begin
            r_dvalid <= 1'b0;
        end
    end

    assign DataOut   = r_dout;
    assign DataValid = r_dvalid;
`endif

    always_comb begin
        Flags              = '0;
        Flags.full         = w_full;
        Flags.empty        = w_empty;
        Flags.almost_full  = (Level >= AF_TH);
        Flags.almost_empty = (Level <= AE_TH);
        Flags.overflow     = r_overflow;
        Flags.underflow    = r_underflow;
    end

endmodule

// File: rtl/multi_channel_sync_fifo.sv
// ----------------------------------------------------------------------------
// multi_channel_sync_fifo
// NumChannels independent single-clock FIFOs sharing Clk/Reset. Each channel
// is a sync_fifo_channel; this level only packs and unpacks the buses.
// Channel c uses bits [c*DataSize +: DataSize] of DataIn/DataOut and
// [c*(AddrSize+1) +: AddrSize+1] of Level.
//
// Macro MULTI_FIFO_FWFT_EN selects first-word fall-through read mode.
//
// Ports:
//   Clk, Reset                      clock, synchronous active-high reset
//   Push, Pop                       per-channel write / read requests
//   DataIn, DataOut, DataValid      per-channel data
//   full, empty                     per-channel occupancy flags
//   almost_full, almost_empty       per-channel threshold flags
//   Level                           per-channel occupancy 0..Depth
//   Overflow, Underflow             one-cycle rejected push / pop pulses
// ----------------------------------------------------------------------------
module multi_channel_sync_fifo
    import multi_fifo_pkg::*;
#(
    parameter int DataSize          = DEF_DATA_SIZE,
    parameter int AddrSize          = DEF_ADDR_SIZE,
    parameter int NumChannels       = DEF_NUM_CHANNELS,
    parameter int AlmostFullThresh  = DEF_ALMOST_FULL_THRESH,
    parameter int AlmostEmptyThresh = DEF_ALMOST_EMPTY_THRESH
) (
    input  logic                                         Clk,
    input  logic                                         Reset,
    input  logic [NumChannels-1:0]                       Push,
    input  logic [NumChannels-1:0]                       Pop,
    input  logic [NumChannels*DataSize-1:0]              DataIn,
    output logic [NumChannels*DataSize-1:0]              DataOut,
    output logic [NumChannels-1:0]                       DataValid,
    output logic [NumChannels-1:0]                       full,
    output logic [NumChannels-1:0]                       empty,
    output logic [NumChannels-1:0]                       almost_full,
    output logic [NumChannels-1:0]                       almost_empty,
    output logic [NumChannels*level_width(AddrSize)-1:0] Level,
    output logic [NumChannels-1:0]                       Overflow,
    output logic [NumChannels-1:0]                       Underflow
);

    localparam int LW = level_width(AddrSize);

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        fifo_flags_t w_flags;

        sync_fifo_channel #(
            .DataSize          (DataSize),
            .AddrSize          (AddrSize),
            .AlmostFullThresh  (AlmostFullThresh),
            .AlmostEmptyThresh (AlmostEmptyThresh)
        ) u_ch (
            .Clk       (Clk),
            .Reset     (Reset),
            .Push      (Push[c]),
            .Pop       (Pop[c]),
            .DataIn    (DataIn[c*DataSize +: DataSize]),
            .DataOut   (DataOut[c*DataSize +: DataSize]),
            .DataValid (DataValid[c]),
            .Level     (Level[c*LW +: LW]),
            .Flags     (w_flags)
        );

        assign full[c]         = w_flags.full;
        assign empty[c]        = w_flags.empty;
        assign almost_full[c]  = w_flags.almost_full;
        assign almost_empty[c] = w_flags.almost_empty;
        assign Overflow[c]     = w_flags.overflow;
        assign Underflow[c]    = w_flags.underflow;
    end

endmodule

// File: tb/tb_multi_channel_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_multi_channel_sync_fifo
// Self-checking bench: a per-channel reference queue is updated whenever
// stimulus is driven and compared against every DUT output after each edge,
// plus a hand-written vector table and directed corner-case sequences.
// ----------------------------------------------------------------------------
module tb_multi_channel_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int NC    = 4;
    localparam int LW    = AW + 1;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [NC-1:0]     Push;
    logic [NC-1:0]     Pop;
    logic [NC*DW-1:0]  DataIn;
    logic [NC*DW-1:0]  DataOut;
    logic [NC-1:0]     DataValid;
    logic [NC-1:0]     full;
    logic [NC-1:0]     empty;
    logic [NC-1:0]     almost_full;
    logic [NC-1:0]     almost_empty;
    logic [NC*LW-1:0]  Level;
    logic [NC-1:0]     Overflow;
    logic [NC-1:0]     Underflow;

    multi_channel_sync_fifo #(
        .DataSize(DW), .AddrSize(AW), .NumChannels(NC),
        .AlmostFullThresh(AF), .AlmostEmptyThresh(AE)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Push(Push), .Pop(Pop), .DataIn(DataIn),
        .DataOut(DataOut), .DataValid(DataValid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .Level(Level),
        .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef logic [DW-1:0] q_t[$];
    q_t            mdl [NC];
    logic [DW-1:0] exp_dout [NC];
    logic          exp_dv   [NC];
    logic          exp_ovf  [NC];
    logic          exp_udf  [NC];

    typedef struct {
        logic [NC-1:0]    push;
        logic [NC-1:0]    pop;
        logic [NC*DW-1:0] din;
        logic [LW-1:0]    lvl0;
        logic             full0;
        logic             af0;
        logic [NC-1:0]    ovf;
        logic [NC-1:0]    udf;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    // Drive one cycle, advance the model, then compare all outputs after the edge
    task automatic step(input logic rst, input logic [NC-1:0] p, input logic [NC-1:0] q,
                        input logic [NC*DW-1:0] d);
        Reset = rst; Push = p; Pop = q; DataIn = d;
        for (int c = 0; c < NC; c++) begin
            int   sz;
            logic pa, wa;
            sz = mdl[c].size();
            if (rst) begin
                mdl[c].delete();
                exp_dout[c] = '0; exp_dv[c] = 1'b0;
                exp_ovf[c] = 1'b0; exp_udf[c] = 1'b0;
            end else begin
                pa = q[c] && (sz != 0);
                wa = p[c] && ((sz != DEPTH) || q[c]);
                exp_ovf[c] = p[c] && (sz == DEPTH) && !q[c];
                exp_udf[c] = q[c] && (sz == 0);
                exp_dv[c]  = 1'b0;
                if (pa) begin
                    exp_dout[c] = mdl[c].pop_front();
                    exp_dv[c]   = 1'b1;
                end
                if (wa) mdl[c].push_back(d[c*DW +: DW]);
            end
        end
        @(posedge Clk); #1;
        for (int c = 0; c < NC; c++) begin
            int sz;
            sz = mdl[c].size();
            chk("level", c, 32'(Level[c*LW +: LW]), sz);
            chk("full", c, 32'(full[c]), 32'(sz == DEPTH));
            chk("empty", c, 32'(empty[c]), 32'(sz == 0));
            chk("almost_full", c, 32'(almost_full[c]), 32'(sz >= AF));
            chk("almost_empty", c, 32'(almost_empty[c]), 32'(sz <= AE));
            chk("overflow", c, 32'(Overflow[c]), 32'(exp_ovf[c]));
            chk("underflow", c, 32'(Underflow[c]), 32'(exp_udf[c]));
`ifdef MULTI_FIFO_FWFT_EN
            chk("data_valid", c, 32'(DataValid[c]), 32'(sz != 0));
            chk("data_out", c, 32'(DataOut[c*DW +: DW]), (sz != 0) ? 32'(mdl[c][0]) : 32'h0);
`else
            chk("data_valid", c, 32'(DataValid[c]), 32'(exp_dv[c]));
            chk("data_out", c, 32'(DataOut[c*DW +: DW]), 32'(exp_dout[c]));
`endif
        end
    endtask

    initial begin
        // Ch0 fill, then overflow on ch0 and underflow on ch1 in one cycle
        for (int i = 0; i < 8; i++) begin
            tbl[i].push  = 4'b0001;
            tbl[i].pop   = 4'b0000;
            tbl[i].din   = 32'(8'h10 + i);
            tbl[i].lvl0  = LW'(i + 1);
            tbl[i].full0 = (i == 7);
            tbl[i].af0   = (i + 1 >= AF);
            tbl[i].ovf   = 4'b0000;
            tbl[i].udf   = 4'b0000;
        end
        tbl[8] = '{push: 4'b0001, pop: 4'b0010, din: 32'h0000_00AA, lvl0: 4'd8,
                   full0: 1'b1, af0: 1'b1, ovf: 4'b0001, udf: 4'b0010};
        tbl[9] = '{push: 4'b0000, pop: 4'b0000, din: 32'h0,         lvl0: 4'd8,
                   full0: 1'b1, af0: 1'b1, ovf: 4'b0000, udf: 4'b0000};

        step(1'b1, '0, '0, '0);
        step(1'b1, '0, '0, '0);
        chk("reset_empty_all", 0, 32'(empty), 32'hF);
        chk("reset_level_all", 0, 32'(Level), 32'h0);

        for (int i = 0; i < 10; i++) begin
            step(1'b0, tbl[i].push, tbl[i].pop, tbl[i].din);
            chk("tbl_level0", i, 32'(Level[LW-1:0]), 32'(tbl[i].lvl0));
            chk("tbl_full0", i, 32'(full[0]), 32'(tbl[i].full0));
            chk("tbl_af0", i, 32'(almost_full[0]), 32'(tbl[i].af0));
            chk("tbl_ovf", i, 32'(Overflow), 32'(tbl[i].ovf));
            chk("tbl_udf", i, 32'(Underflow), 32'(tbl[i].udf));
            chk("tbl_others_empty", i, 32'(empty[NC-1:1]), 32'h7);
        end

        // Drain ch0: 0x10..0x17 in order, 0xAA never stored
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0000, 4'b0001, '0);
        step(1'b0, '0, '0, '0);

        // Ch2 full, simultaneous push/pop, then drain (0x55 comes last)
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0100, 4'b0000, 32'(8'h20 + i) << 16);
        step(1'b0, 4'b0100, 4'b0100, 32'h0055_0000);
        chk("ch2_simul_level", 2, 32'(Level[2*LW +: LW]), 32'd8);
`ifndef MULTI_FIFO_FWFT_EN
        chk("ch2_simul_dout", 2, 32'(DataOut[23:16]), 32'h20);
`endif
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0000, 4'b0100, '0);
`ifndef MULTI_FIFO_FWFT_EN
        chk("ch2_last_dout", 2, 32'(DataOut[23:16]), 32'h55);
`endif

        // Ch3 streaming through pointer wrap
        step(1'b0, 4'b1000, 4'b0000, 32'h3000_0000);
        for (int i = 1; i < 20; i++) begin
            step(1'b0, 4'b1000, 4'b1000, 32'(8'h30 + i) << 24);
            chk("ch3_level_le2", 3, 32'(Level[3*LW +: LW] <= 4'd2), 32'h1);
        end
        step(1'b0, 4'b0000, 4'b1000, '0);

        // Reset with 5 words in ch0; push/pop during reset are ignored
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0001, 4'b0000, 32'(8'h40 + i));
        step(1'b1, 4'b0001, 4'b0001, 32'h0000_0099);
        chk("rst_mid_level0", 0, 32'(Level[LW-1:0]), 32'h0);
        chk("rst_mid_dv0", 0, 32'(DataValid[0]), 32'h0);
        step(1'b0, 4'b0001, 4'b0000, 32'h0000_0033);
`ifdef MULTI_FIFO_FWFT_EN
        chk("fwft_dout0", 0, 32'(DataOut[7:0]), 32'h33);
        chk("fwft_dv0", 0, 32'(DataValid[0]), 32'h1);
`endif
        step(1'b0, 4'b0000, 4'b0001, '0);
        step(1'b0, '0, '0, '0);

        // Random traffic on all channels with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), NC'($urandom), NC'($urandom), 32'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_channel_sync_fifo.md
Name: multi_channel_sync_fifo

Overview:
- NumChannels independent single-clock FIFOs sharing one Clk and one Reset.
- Generalised successor of the team's dual-clock FIFO. Adds parametrised channel count, per-channel fill level, programmable almost-full/almost-empty flags, and overflow/underflow error pulses.
- Sits between packet producers and arbiters in the single-clock domain, where no clock-domain crossing is needed.

Parameters:
- DataSize, 8, data width per channel in bits.
- AddrSize, 3, address width; Depth = 2**AddrSize entries per channel.
- NumChannels, 4, number of independent FIFO channels (minimum 1).
- AlmostFullThresh, 6, almost_full asserts when Level >= this value (range 1..Depth).
- AlmostEmptyThresh, 1, almost_empty asserts when Level <= this value (range 0..Depth-1).

Ports:
- Clk  in  1  single clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- Push  in  NumChannels  per-channel write request.
- Pop  in  NumChannels  per-channel read request.
- DataIn  in  NumChannels*DataSize  write data; channel c occupies bits [c*DataSize +: DataSize].
- DataOut  out  NumChannels*DataSize  read data, same packing as DataIn.
- DataValid  out  NumChannels  DataOut of the channel is valid.
- full  out  NumChannels  channel holds Depth entries.
- empty  out  NumChannels  channel holds 0 entries.
- almost_full  out  NumChannels  Level >= AlmostFullThresh.
- almost_empty  out  NumChannels  Level <= AlmostEmptyThresh.
- Level  out  NumChannels*(AddrSize+1)  per-channel occupancy, 0..Depth.
- Overflow  out  NumChannels  one-cycle pulse when a push is rejected.
- Underflow  out  NumChannels  one-cycle pulse when a pop is rejected.

Behaviour:
- Single clock; Reset is synchronous and active-high, sampled on posedge Clk.
- Reset values per channel:
  - WritePtr = ReadPtr = 0, so Level = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - DataOut = 0, DataValid = 0, Overflow = 0, Underflow = 0.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all channel contents at that edge. Push/Pop in the reset cycle are ignored.
- Pointers are AddrSize+1 bits wide:
  - Memory index = low AddrSize bits.
  - Level = WritePtr - ReadPtr, modulo 2**(AddrSize+1).
  - empty = (pointers equal).
  - full = (MSBs differ and low bits equal).
- Pointer wrap-around is natural binary rollover; no special case.
- Flags and Level are combinational from registered pointers. They reflect an accepted operation in the cycle after the edge on which it occurred.
- Accepted push: Push && (!full || Pop). Writes DataIn to mem[WritePtr] and increments WritePtr.
- Accepted pop: Pop && !empty. Increments ReadPtr.
- Push while full with no Pop: ignored, Overflow = 1 for the next cycle only.
- Pop while empty: ignored, Underflow = 1 for the next cycle only. A simultaneous Push is still accepted.
- Push and Pop together while full: both accepted; Level stays at Depth.
- Push and Pop together at any other non-empty level: both accepted; Level unchanged.
- Read timing in default mode (macro undefined):
  - On an accepted pop, DataOut <= mem[ReadPtr] and DataValid <= 1. Latency is 1 cycle.
  - DataValid = 0 in any cycle that follows a non-accepted pop; DataOut holds its last value.
- Channels are fully independent; no cross-channel interaction.

Optional Feature:
- Macro: MULTI_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - DataOut = mem[ReadPtr] combinationally whenever !empty, else 0.
  - DataValid = !empty.
  - Pop acknowledges the presented word; the next word appears in the following cycle.
  - The read register is removed.
- Undefined: registered-read behaviour with 1-cycle latency, as described above.

Decomposition:
- Package multi_fifo_pkg:
  - typedef struct fifo_flags_t {full, empty, almost_full, almost_empty, overflow, underflow}.
  - function level_width(AddrSize).
  - Default parameter constants.
- Sub-module sync_fifo_channel: one channel with the same parameters and scalar ports. The top instantiates NumChannels copies in a generate loop and packs/unpacks the buses.

Test Plan:
- Reset, then push 8 words 0x10..0x17 on ch0 (Depth 8) -> full[0]=1, Level[0]=8, almost_full[0]=1 when Level reaches 6. Other channels stay empty=1.
- Ch0 full, push 0xAA without Pop -> Overflow[0] pulses 1 cycle, Level stays 8. Popping 8 returns 0x10..0x17 in order, 0xAA never appears.
- Ch1 empty, Pop=1 -> Underflow[1] pulses 1 cycle, DataValid[1]=0, Level[1]=0.
- Ch2 full, Push and Pop together with DataIn=0x55 -> DataOut=oldest word, Level stays 8. 0x55 is read out after the remaining 7 words.
- Push/pop 20 words continuously on ch3 -> pointers wrap, data in equals data out. Level never exceeds 2; Overflow and Underflow stay 0.
- Reset asserted with 5 words in ch0 -> next cycle Level[0]=0, empty[0]=1, DataValid=0. With MULTI_FIFO_FWFT_EN defined, a single push 0x33 -> DataOut[0]=0x33 and DataValid[0]=1 in the following cycle, before any Pop.
